// File: rtl/mbe_pp_gen.sv
// Sequential radix-4 modified-Booth partial-product generator: one row per GEN cycle.
// Define MBE_ZERO_SKIP_EN to finish early once the remaining multiplier bits are all zero.
module mbe_pp_gen #(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          a,
    input  logic [N-1:0]          b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N/2:0][N:0]     pp,
    output logic [N/2:0]          signs
);

    localparam int ROWS = N / 2 + 1;
    localparam int COLS = N + 1;
    localparam int RW   = $clog2(ROWS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [COLS-1:0] a_q;
    // {b_ext, 1'b0} shifted right two bits per row: [2:0] is always the current Booth digit
    logic [N+2:0]    b_sh;
    logic [RW-1:0]   row;
    logic [COLS-1:0] mag;
    logic [COLS-1:0] row_val;
    logic            neg;
    logic            gen_end;

    always_comb begin
        mag = '0;
        unique case (b_sh[2:0])
            3'b001, 3'b010, 3'b101, 3'b110: mag = a_q;
            3'b011, 3'b100:                 mag = a_q << 1;
            default:                        mag = '0;
        endcase
        neg     = b_sh[2] & ~(b_sh[1] & b_sh[0]);
        row_val = neg ? ~mag : mag;
    end

    always_comb begin
`ifdef MBE_ZERO_SKIP_EN
        gen_end = (row == ROW_LAST) || (b_sh == '0);
`else
        gen_end = (row == ROW_LAST);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = GEN;
            GEN:     if (gen_end)   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_sh  <= '0;
            row   <= '0;
            pp    <= '0;
            signs <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= {1'b0, a};
                        b_sh  <= {2'b00, b, 1'b0};
                        row   <= '0;
                        pp    <= '0;
                        signs <= '0;
                    end
                end
                GEN: begin
                    // A zero digit writes an all-zero row, so early exit leaves identical data
                    pp[row]    <= row_val;
                    signs[row] <= neg;
                    b_sh       <= b_sh >> 2;
                    row        <= row + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mbe_pp_gen.sv
// Directed and random checks of mbe_pp_gen at N=8; latency expectations follow MBE_ZERO_SKIP_EN.
module tb_mbe_pp_gen;

    localparam int N    = 8;
    localparam int ROWS = 5;
    localparam int COLS = 9;

`ifdef MBE_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic [N-1:0]               a;
    logic [N-1:0]               b;
    logic                       out_valid;
    logic                       out_ready;
    logic [ROWS-1:0][COLS-1:0]  pp;
    logic [ROWS-1:0]            signs;

    int checks = 0;
    int passes = 0;

    mbe_pp_gen #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pp        (pp),
        .signs     (signs)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Rows are sign-extended through their sign bit; the sign is then added at the row LSB.
    function automatic longint row_sum(input logic [ROWS-1:0][COLS-1:0] p, input logic [ROWS-1:0] s);
        longint acc = 0;
        for (int i = 0; i < ROWS; i++) begin
            longint r = longint'(p[i]);
            if (s[i]) r = r - 512;
            acc += (r + longint'(s[i])) <<< (2 * i);
        end
        return acc;
    endfunction

    task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv);
        @(negedge clk);
        check("ready_before_op", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_xfer", {62'd0, in_ready, out_valid}, 64'h2);
    endtask

    initial begin
        int lat;
        int seen;
        logic [63:0] snap;
        logic [N-1:0] av, bv;
        bit done;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        check("reset_pp",        pp,                    64'd0);
        check("reset_signs",     signs,                 64'd0);
        check("reset_handshake", {in_ready, out_valid}, 64'h2);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // a=5, b=3 with a 10-cycle output stall and ignored in_valid
        start_op(8'd5, 8'd3);
        wait_done(lat);
        check("lat_5x3",     lat,      SKIP ? 64'd3 : 64'd5);
        check("pp0_5x3",     pp[0],    64'h1FA);
        check("pp1_5x3",     pp[1],    64'h005);
        check("pp4to2_5x3",  pp[4:2],  64'd0);
        check("signs_5x3",   signs,    64'h01);
        check("sum_5x3",     row_sum(pp, signs), 64'd15);
        snap     = {9'd0, pp, signs};
        in_valid = 1'b1;
        a        = 8'h77;
        b        = 8'h99;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_data",      {9'd0, pp, signs},     snap);
            check("stall_handshake", {in_ready, out_valid}, 64'h1);
        end
        in_valid = 1'b0;
        drain();
        repeat (2) @(negedge clk);
        check("idle_retains", {9'd0, pp, signs}, snap);

        // a=0xFF, b=0xFF
        start_op(8'hFF, 8'hFF);
        wait_done(lat);
        check("lat_ffxff",    lat,      64'd5);
        check("pp0_ffxff",    pp[0],    64'h100);
        check("pp3to1_ffxff", pp[3:1],  64'd0);
        check("pp4_ffxff",    pp[4],    64'h0FF);
        check("signs_ffxff",  signs,    64'h01);
        check("sum_ffxff",    row_sum(pp, signs), 64'hFE01);
        drain();

        // a=7, b=6 exercises -2a and +2a
        start_op(8'd7, 8'd6);
        wait_done(lat);
        check("lat_7x6",    lat,      SKIP ? 64'd3 : 64'd5);
        check("pp0_7x6",    pp[0],    64'h1F1);
        check("pp1_7x6",    pp[1],    64'h00E);
        check("pp4to2_7x6", pp[4:2],  64'd0);
        check("signs_7x6",  signs,    64'h01);
        check("sum_7x6",    row_sum(pp, signs), 64'd42);
        drain();

        // b=0
        start_op(8'hA5, 8'h00);
        wait_done(lat);
        check("lat_b0",   lat,   SKIP ? 64'd1 : 64'd5);
        check("pp_b0",    pp,    64'd0);
        check("signs_b0", signs, 64'd0);
        drain();

        // out_ready already high when DONE is entered: single-cycle out_valid
        out_ready = 1'b1;
        start_op(8'h80, 8'h80);
        wait_done(lat);
        check("lat_80x80",    lat,     64'd5);
        check("pp3_80x80",    pp[3],   64'h0FF);
        check("pp4_80x80",    pp[4],   64'h080);
        check("signs_80x80",  signs,   64'h08);
        check("sum_80x80",    row_sum(pp, signs), 64'h4000);
        @(negedge clk);
        out_ready = 1'b0;
        check("early_ready_xfer", {in_ready, out_valid}, 64'h2);

        // reset in the second GEN cycle discards the operation
        start_op(8'd5, 8'd3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_pp",        pp,                    64'd0);
        check("midrst_signs",     signs,                 64'd0);
        check("midrst_handshake", {in_ready, out_valid}, 64'h2);
        #1;
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_valid", seen, 64'd0);
        start_op(8'd1, 8'd1);
        wait_done(lat);
        check("lat_1x1",    lat,     SKIP ? 64'd2 : 64'd5);
        check("pp0_1x1",    pp[0],   64'h001);
        check("pp4to1_1x1", pp[4:1], 64'd0);
        check("signs_1x1",  signs,   64'd0);
        drain();

        // random operands with random output stalls
        for (int k = 0; k < 1000; k++) begin
            av = N'($urandom);
            bv = N'($urandom);
            start_op(av, bv);
            done = 1'b0;
            for (int c = 0; c < 60 && !done; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    check("rand_sum", row_sum(pp, signs), 64'(longint'(av) * longint'(bv)));
                    done = 1'b1;
                end
                @(negedge clk);
            end
            out_ready = 1'b0;
            if (!done) check("rand_timeout", 64'd0, 64'd1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
